// File: rtl/rpc2_ctrl_pkg.sv
// Shared constants for the RPC2 controller: AXI burst/response encodings and
// the register-bridge FSM state encoding.
package rpc2_ctrl_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_DATA = 3'd4;
  localparam logic [2:0] ST_WR_RESP = 3'd5;

endpackage

// File: rtl/rpc2_ctrl_axi_reg_bridge.sv
// AXI4 slave to register-interface bridge: one transaction in flight, fair
// AW/AR arbitration, zero-cycle data passthrough in the data phases.
module rpc2_ctrl_axi_reg_bridge
  import rpc2_ctrl_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [C_AXI_ID_WIDTH-1:0] s_axi_awid,
  input  logic [31:0]               s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [C_AXI_ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [C_AXI_ID_WIDTH-1:0] s_axi_arid,
  input  logic [31:0]               s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [C_AXI_ID_WIDTH-1:0] s_axi_rid,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      axi2ip_valid,
  output logic                      axi2ip_rw_n,
  output logic [31:0]               axi2ip_address,
  output logic [1:0]                axi2ip_size,
  output logic [1:0]                axi2ip_burst,
  output logic [7:0]                axi2ip_len,
  output logic [3:0]                axi2ip_strb,
  output logic [31:0]               axi2ip_data,
  output logic                      axi2ip_data_valid,
  output logic                      axi2ip_data_ready,
  input  logic                      ip_ready,
  input  logic                      ip_data_ready,
  input  logic [31:0]               ip_data,
  input  logic                      ip_data_valid,
  input  logic                      ip_data_last,
  input  logic [1:0]                ip_rd_error,
  input  logic                      ip_wr_done,
  input  logic [1:0]                ip_wr_error
);

  logic [2:0]                state_r;
  logic [2:0]                next_state_s;
  logic [C_AXI_ID_WIDTH-1:0] id_r;
  logic [31:0]               addr_r;
  logic [7:0]                len_r;
  logic [1:0]                size_r;
  logic [1:0]                burst_r;
  logic                      rw_n_r;
  logic [1:0]                bresp_r;
  logic                      last_wr_r;
  logic                      idle_s;
  logic                      wr_data_s;
  logic                      rd_data_s;
  logic                      grant_wr_s;
  logic                      grant_rd_s;
  logic                      unused_s;

  // wlast and size bit 2 carry no meaning for the register side
  assign unused_s = ^{s_axi_wlast, s_axi_awsize[2], s_axi_arsize[2]};

  assign idle_s     = (state_r == ST_IDLE);
  assign wr_data_s  = (state_r == ST_WR_DATA);
  assign rd_data_s  = (state_r == ST_RD_DATA);
  // Write wins a tie unless it was the previous grant.
  assign grant_wr_s = s_axi_awvalid & (~s_axi_arvalid | ~last_wr_r);
  assign grant_rd_s = s_axi_arvalid & ~grant_wr_s;

  assign s_axi_awready     = idle_s & grant_wr_s;
  assign s_axi_arready     = idle_s & grant_rd_s;
  assign s_axi_wready      = wr_data_s & ip_data_ready;
  assign axi2ip_data_valid = wr_data_s & s_axi_wvalid;
  assign axi2ip_data       = wr_data_s ? s_axi_wdata : 32'h0000_0000;
  assign axi2ip_strb       = wr_data_s ? s_axi_wstrb : 4'h0;
  assign s_axi_bvalid      = (state_r == ST_WR_RESP);
  assign s_axi_bid         = id_r;
  assign s_axi_bresp       = bresp_r;
  assign s_axi_rvalid      = rd_data_s & ip_data_valid;
  assign s_axi_rdata       = rd_data_s ? ip_data : 32'h0000_0000;
  assign s_axi_rresp       = rd_data_s ? ip_rd_error : RESP_OKAY;
  assign s_axi_rlast       = rd_data_s & ip_data_last;
  assign s_axi_rid         = id_r;
  assign axi2ip_data_ready = rd_data_s & s_axi_rready;
  assign axi2ip_valid      = (state_r == ST_RD_REQ) | (state_r == ST_WR_REQ);
  assign axi2ip_rw_n       = rw_n_r;
  assign axi2ip_address    = addr_r;
  assign axi2ip_size       = size_r;
  assign axi2ip_burst      = burst_r;
  assign axi2ip_len        = len_r;

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_wr_s) next_state_s = ST_WR_REQ;
        else if (grant_rd_s) next_state_s = ST_RD_REQ;
        else next_state_s = ST_IDLE;
      end
      ST_RD_REQ: begin
        if (ip_ready) next_state_s = ST_RD_DATA;
        else next_state_s = ST_RD_REQ;
      end
      ST_RD_DATA: begin
        if (ip_data_valid && s_axi_rready && ip_data_last) next_state_s = ST_IDLE;
        else next_state_s = ST_RD_DATA;
      end
      ST_WR_REQ: begin
        if (ip_ready) next_state_s = ST_WR_DATA;
        else next_state_s = ST_WR_REQ;
      end
      ST_WR_DATA: begin
        if (ip_wr_done) next_state_s = ST_WR_RESP;
        else next_state_s = ST_WR_DATA;
      end
      ST_WR_RESP: begin
        if (s_axi_bready) next_state_s = ST_IDLE;
        else next_state_s = ST_WR_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, request latch, write status and arbitration pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      id_r      <= {C_AXI_ID_WIDTH{1'b0}};
      addr_r    <= 32'h0000_0000;
      len_r     <= 8'h00;
      size_r    <= 2'b00;
      burst_r   <= 2'b00;
      rw_n_r    <= 1'b0;
      bresp_r   <= RESP_OKAY;
      last_wr_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (idle_s && grant_wr_s) begin
        id_r      <= s_axi_awid;
        addr_r    <= s_axi_awaddr;
        len_r     <= s_axi_awlen;
        size_r    <= s_axi_awsize[1:0];
        burst_r   <= s_axi_awburst;
        rw_n_r    <= 1'b0;
        last_wr_r <= 1'b1;
      end else if (idle_s && grant_rd_s) begin
        id_r      <= s_axi_arid;
        addr_r    <= s_axi_araddr;
        len_r     <= s_axi_arlen;
        size_r    <= s_axi_arsize[1:0];
        burst_r   <= s_axi_arburst;
        rw_n_r    <= 1'b1;
        last_wr_r <= 1'b0;
      end
      if (wr_data_s && ip_wr_done) bresp_r <= ip_wr_error;
    end
  end

endmodule

// File: tb/tb_rpc2_ctrl_axi_reg_bridge.sv
// Directed self-checking bench for the AXI register bridge; the bench plays
// both the AXI master and the register-side IP.
module tb_rpc2_ctrl_axi_reg_bridge;

  logic        clk;
  logic        reset_n;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        axi2ip_valid;
  logic        axi2ip_rw_n;
  logic [31:0] axi2ip_address;
  logic [1:0]  axi2ip_size;
  logic [1:0]  axi2ip_burst;
  logic [7:0]  axi2ip_len;
  logic [3:0]  axi2ip_strb;
  logic [31:0] axi2ip_data;
  logic        axi2ip_data_valid;
  logic        axi2ip_data_ready;
  logic        ip_ready;
  logic        ip_data_ready;
  logic [31:0] ip_data;
  logic        ip_data_valid;
  logic        ip_data_last;
  logic [1:0]  ip_rd_error;
  logic        ip_wr_done;
  logic [1:0]  ip_wr_error;

  int vec_cnt;
  int err_cnt;

  rpc2_ctrl_axi_reg_bridge #(.C_AXI_ID_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .axi2ip_valid(axi2ip_valid), .axi2ip_rw_n(axi2ip_rw_n),
    .axi2ip_address(axi2ip_address), .axi2ip_size(axi2ip_size),
    .axi2ip_burst(axi2ip_burst), .axi2ip_len(axi2ip_len),
    .axi2ip_strb(axi2ip_strb), .axi2ip_data(axi2ip_data),
    .axi2ip_data_valid(axi2ip_data_valid), .axi2ip_data_ready(axi2ip_data_ready),
    .ip_ready(ip_ready), .ip_data_ready(ip_data_ready),
    .ip_data(ip_data), .ip_data_valid(ip_data_valid), .ip_data_last(ip_data_last),
    .ip_rd_error(ip_rd_error), .ip_wr_done(ip_wr_done), .ip_wr_error(ip_wr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_axi_awid = 4'h0; s_axi_awaddr = 32'h0; s_axi_awlen = 8'h0; s_axi_awsize = 3'b010;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = 4'h0; s_axi_araddr = 32'h0; s_axi_arlen = 8'h0; s_axi_arsize = 3'b010;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    ip_ready = 1'b0; ip_data_ready = 1'b0; ip_data = 32'h0; ip_data_valid = 1'b0;
    ip_data_last = 1'b0; ip_rd_error = 2'b00; ip_wr_done = 1'b0; ip_wr_error = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({axi2ip_valid, s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready} !== 5'b00000) begin
      err_cnt++;
      $display("FAIL reset_valids: got %b exp 00000",
               {axi2ip_valid, s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready});
    end
    vec_cnt++;
    if (s_axi_bresp !== 2'b00 || axi2ip_address !== 32'h0 || axi2ip_len !== 8'h0) begin
      err_cnt++;
      $display("FAIL reset_latch: bresp %b addr %h len %h exp 00/0/0",
               s_axi_bresp, axi2ip_address, axi2ip_len);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    s_axi_awvalid = 1'b1; s_axi_awid = 4'h5; s_axi_awaddr = 32'h0000_0008;
    s_axi_awlen = 8'h00; s_axi_awburst = 2'b01;
    #1;
    vec_cnt++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b0) begin
      err_cnt++;
      $display("FAIL wr_awready: got aw %b ar %b exp 1 0", s_axi_awready, s_axi_arready);
    end
    tick();
    s_axi_awvalid = 1'b0;
    #1;
    vec_cnt++;
    if (axi2ip_valid !== 1'b1 || axi2ip_rw_n !== 1'b0 || axi2ip_address !== 32'h8 || axi2ip_len !== 8'h0) begin
      err_cnt++;
      $display("FAIL wr_req: valid %b rw_n %b addr %h len %h exp 1 0 8 0",
               axi2ip_valid, axi2ip_rw_n, axi2ip_address, axi2ip_len);
    end
    ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hA5A5_A5A5; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
    ip_data_ready = 1'b1; ip_wr_done = 1'b1; ip_wr_error = 2'b00;
    #1;
    vec_cnt++;
    if (axi2ip_valid !== 1'b0 || axi2ip_data_valid !== 1'b1 || s_axi_wready !== 1'b1) begin
      err_cnt++;
      $display("FAIL wr_beat_hs: valid %b dvalid %b wready %b exp 0 1 1",
               axi2ip_valid, axi2ip_data_valid, s_axi_wready);
    end
    vec_cnt++;
    if (axi2ip_data !== 32'hA5A5_A5A5 || axi2ip_strb !== 4'hF) begin
      err_cnt++;
      $display("FAIL wr_beat_data: got %h/%h exp a5a5a5a5/f", axi2ip_data, axi2ip_strb);
    end
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; ip_data_ready = 1'b0; ip_wr_done = 1'b0;
    #1;
    vec_cnt++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 4'h5 || s_axi_bresp !== 2'b00) begin
      err_cnt++;
      $display("FAIL wr_resp: bvalid %b bid %h bresp %b exp 1 5 00", s_axi_bvalid, s_axi_bid, s_axi_bresp);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    vec_cnt++;
    if (s_axi_bvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL wr_resp_done: bvalid %b exp 0", s_axi_bvalid);
    end
  endtask

  task automatic test_read_burst();
    int k;
    int beats;
    k = 0;
    beats = 0;
    s_axi_arvalid = 1'b1; s_axi_arid = 4'h3; s_axi_araddr = 32'h0000_0010;
    s_axi_arlen = 8'h03; s_axi_arburst = 2'b01;
    #1;
    vec_cnt++;
    if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b0) begin
      err_cnt++;
      $display("FAIL rd_arready: got ar %b aw %b exp 1 0", s_axi_arready, s_axi_awready);
    end
    tick();
    s_axi_arvalid = 1'b0;
    #1;
    vec_cnt++;
    if (axi2ip_valid !== 1'b1 || axi2ip_rw_n !== 1'b1 || axi2ip_address !== 32'h10 || axi2ip_len !== 8'h3) begin
      err_cnt++;
      $display("FAIL rd_req: valid %b rw_n %b addr %h len %h exp 1 1 10 3",
               axi2ip_valid, axi2ip_rw_n, axi2ip_address, axi2ip_len);
    end
    ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      s_axi_rready = (c % 2 == 0) ? 1'b1 : 1'b0;
      ip_data_valid = 1'b1;
      ip_data = 32'h1000_0000 + k;
      ip_data_last = (k == 3) ? 1'b1 : 1'b0;
      #1;
      vec_cnt++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h1000_0000 + k || s_axi_rlast !== (k == 3)
          || s_axi_rid !== 4'h3 || axi2ip_data_ready !== s_axi_rready) begin
        err_cnt++;
        $display("FAIL rd_beat%0d: rvalid %b rdata %h rlast %b rid %h dready %b exp 1 %h %b 3 %b",
                 c, s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rid, axi2ip_data_ready,
                 32'h1000_0000 + k, (k == 3), s_axi_rready);
      end
      if (s_axi_rvalid === 1'b1 && s_axi_rready === 1'b1) begin
        beats++;
        k++;
      end
      tick();
    end
    s_axi_rready = 1'b1;
    #1;
    vec_cnt++;
    if (s_axi_rvalid !== 1'b0 || beats != 4) begin
      err_cnt++;
      $display("FAIL rd_burst_end: rvalid %b beats %0d exp 0 4", s_axi_rvalid, beats);
    end
    ip_data_valid = 1'b0; ip_data_last = 1'b0; s_axi_rready = 1'b0;
  endtask

  task automatic test_back_to_back();
    s_axi_awvalid = 1'b1; s_axi_awid = 4'hA; s_axi_awaddr = 32'h20;
    s_axi_arvalid = 1'b1; s_axi_arid = 4'hB; s_axi_araddr = 32'h30; s_axi_arlen = 8'h00;
    #1;
    vec_cnt++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b0) begin
      err_cnt++;
      $display("FAIL arb_first: aw %b ar %b exp 1 0", s_axi_awready, s_axi_arready);
    end
    tick();
    s_axi_awvalid = 1'b0;
    ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0; ip_wr_done = 1'b1;
    tick();
    ip_wr_done = 1'b0; s_axi_bready = 1'b1;
    #1;
    vec_cnt++;
    if (s_axi_arready !== 1'b0 || s_axi_bid !== 4'hA) begin
      err_cnt++;
      $display("FAIL arb_busy: arready %b bid %h exp 0 a", s_axi_arready, s_axi_bid);
    end
    tick();
    s_axi_bready = 1'b0; s_axi_awvalid = 1'b1;
    #1;
    vec_cnt++;
    if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b0) begin
      err_cnt++;
      $display("FAIL arb_second: ar %b aw %b exp 1 0", s_axi_arready, s_axi_awready);
    end
    tick();
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
    ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0; ip_data_valid = 1'b1; ip_data_last = 1'b1; ip_data = 32'h5A; s_axi_rready = 1'b1;
    #1;
    vec_cnt++;
    if (s_axi_rid !== 4'hB || s_axi_rlast !== 1'b1) begin
      err_cnt++;
      $display("FAIL arb_rd_beat: rid %h rlast %b exp b 1", s_axi_rid, s_axi_rlast);
    end
    tick();
    ip_data_valid = 1'b0; ip_data_last = 1'b0; s_axi_rready = 1'b0;
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    #1;
    vec_cnt++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b0) begin
      err_cnt++;
      $display("FAIL arb_third: aw %b ar %b exp 1 0", s_axi_awready, s_axi_arready);
    end
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    s_axi_awvalid = 1'b1; s_axi_awid = 4'h7; s_axi_awaddr = 32'h0000_0100; s_axi_awlen = 8'h0;
    tick();
    s_axi_awvalid = 1'b0; ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0; ip_wr_done = 1'b1; ip_wr_error = 2'b11;
    tick();
    ip_wr_done = 1'b0; ip_wr_error = 2'b00;
    #1;
    vec_cnt++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b11 || s_axi_bid !== 4'h7) begin
      err_cnt++;
      $display("FAIL err_decerr: bvalid %b bresp %b bid %h exp 1 11 7", s_axi_bvalid, s_axi_bresp, s_axi_bid);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b1; s_axi_arid = 4'h2; s_axi_araddr = 32'h44; s_axi_arlen = 8'h0;
    s_axi_arburst = 2'b10;
    tick();
    s_axi_arvalid = 1'b0; s_axi_arburst = 2'b01;
    #1;
    vec_cnt++;
    if (axi2ip_burst !== 2'b10 || axi2ip_rw_n !== 1'b1) begin
      err_cnt++;
      $display("FAIL err_wrap: burst %b rw_n %b exp 10 1", axi2ip_burst, axi2ip_rw_n);
    end
    ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0; ip_data_valid = 1'b1; ip_data_last = 1'b1; ip_rd_error = 2'b10;
    s_axi_rready = 1'b1;
    #1;
    vec_cnt++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rresp !== 2'b10) begin
      err_cnt++;
      $display("FAIL err_slverr: rvalid %b rresp %b exp 1 10", s_axi_rvalid, s_axi_rresp);
    end
    tick();
    ip_data_valid = 1'b0; ip_data_last = 1'b0; ip_rd_error = 2'b00; s_axi_rready = 1'b0;
  endtask

  task automatic test_ip_stall();
    s_axi_arvalid = 1'b1; s_axi_arid = 4'h6; s_axi_araddr = 32'h40; s_axi_arlen = 8'h01;
    s_axi_arsize = 3'b110;
    tick();
    s_axi_arvalid = 1'b0; s_axi_araddr = 32'hFFFF_FFFF; s_axi_arlen = 8'hFF; s_axi_arsize = 3'b010;
    ip_data_valid = 1'b1; s_axi_rready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vec_cnt++;
      if (axi2ip_valid !== 1'b1 || axi2ip_address !== 32'h40 || axi2ip_len !== 8'h01
          || axi2ip_size !== 2'b10 || s_axi_rvalid !== 1'b0) begin
        err_cnt++;
        $display("FAIL stall_c%0d: valid %b addr %h len %h size %b rvalid %b exp 1 40 01 10 0",
                 c, axi2ip_valid, axi2ip_address, axi2ip_len, axi2ip_size, s_axi_rvalid);
      end
      tick();
    end
    ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0; ip_data_last = 1'b1;
    #1;
    vec_cnt++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rid !== 4'h6) begin
      err_cnt++;
      $display("FAIL stall_release: rvalid %b rid %h exp 1 6", s_axi_rvalid, s_axi_rid);
    end
    tick();
    ip_data_valid = 1'b0; ip_data_last = 1'b0; s_axi_rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    s_axi_awvalid = 1'b1; s_axi_awid = 4'h4; s_axi_awaddr = 32'h80; s_axi_awlen = 8'h03;
    tick();
    s_axi_awvalid = 1'b0; ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0; s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1111_1111; s_axi_wstrb = 4'hF;
    ip_data_ready = 1'b1;
    tick();
    s_axi_wdata = 32'h2222_2222;
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({s_axi_wready, axi2ip_data_valid, axi2ip_valid, s_axi_bvalid, s_axi_rvalid} !== 5'b00000
        || axi2ip_address !== 32'h0) begin
      err_cnt++;
      $display("FAIL rst_mid: wready %b dvalid %b valid %b bvalid %b rvalid %b addr %h exp 0s",
               s_axi_wready, axi2ip_data_valid, axi2ip_valid, s_axi_bvalid, s_axi_rvalid, axi2ip_address);
    end
    tick();
    reset_n = 1'b1; s_axi_wvalid = 1'b0; ip_data_ready = 1'b0;
    s_axi_awvalid = 1'b1; s_axi_awid = 4'h9; s_axi_awaddr = 32'h0C; s_axi_awlen = 8'h00;
    s_axi_arvalid = 1'b1;
    #1;
    vec_cnt++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_arb: aw %b ar %b exp 1 0", s_axi_awready, s_axi_arready);
    end
    tick();
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    #1;
    vec_cnt++;
    if (axi2ip_valid !== 1'b1 || axi2ip_address !== 32'h0C) begin
      err_cnt++;
      $display("FAIL rst_wr_req: valid %b addr %h exp 1 0c", axi2ip_valid, axi2ip_address);
    end
    ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0; s_axi_wvalid = 1'b1; s_axi_wdata = 32'h3333_3333; ip_data_ready = 1'b1;
    ip_wr_done = 1'b1;
    tick();
    s_axi_wvalid = 1'b0; ip_data_ready = 1'b0; ip_wr_done = 1'b0;
    #1;
    vec_cnt++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 4'h9 || s_axi_bresp !== 2'b00) begin
      err_cnt++;
      $display("FAIL rst_wr_resp: bvalid %b bid %h bresp %b exp 1 9 00", s_axi_bvalid, s_axi_bid, s_axi_bresp);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_single_write();
    test_read_burst();
    test_back_to_back();
    test_errors();
    test_ip_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
